// File: rtl/traffic_pkg.sv
// Shared types and constants for the N-approach traffic light controller:
// FSM states, interval register selects and lamp bit offsets.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN_BASE = 2'd0,
        GREEN_EXT  = 2'd1,
        YELLOW     = 2'd2,
        WALK       = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        TP_BASE = 2'b00,
        TP_EXT  = 2'b01,
        TP_YEL  = 2'b10,
        TP_WALK = 2'b11
    } tp_sel_e;

    // Bit offsets of each lamp inside an approach's 3-bit lamp group.
    localparam int RED = 0;
    localparam int YEL = 1;
    localparam int GRN = 2;

    // Interval register that times a given state.
    function automatic tp_sel_e state_tp(input state_e s);
        case (s)
            GREEN_BASE: return TP_BASE;
            GREEN_EXT:  return TP_EXT;
            YELLOW:     return TP_YEL;
            default:    return TP_WALK;
        endcase
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Interval timer: a TICK_DIV-cycle prescaler feeding a TW-bit tick down-counter.
// expire pulses for one cycle in the last clk cycle of the loaded interval.
module tick_timer #(
    parameter int TICK_DIV = 4,
    parameter int TW       = 4,
    parameter int RST_VAL  = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          expire
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;
    logic [TW-1:0] cnt;
    logic          pre_last;

    assign pre_last = (pre == PRE_LAST);
    assign expire   = pre_last && (cnt == TW'(1));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
            cnt <= TW'(RST_VAL);
        end else if (load) begin
            pre <= '0;
            cnt <= load_val;
        end else if (pre_last) begin
            pre <= '0;
            if (cnt > TW'(1))
                cnt <= cnt - TW'(1);
        end else begin
            pre <= pre + PW'(1);
        end
    end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// Round-robin N-approach traffic light controller with one-shot green
// extension, all-red pedestrian walk phase and reprogrammable intervals.
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int N_APPROACH = 2,
    parameter int TICK_DIV   = 100_000_000,
    parameter int TW         = 4,
    parameter int DEF_BASE   = 6,
    parameter int DEF_EXT    = 3,
    parameter int DEF_YEL    = 2,
    parameter int DEF_WALK   = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_APPROACH-1:0]         sensor,
    input  logic                          walk,
    input  logic                          reprogram,
    input  logic [1:0]                    tp_sel,
    input  logic [TW-1:0]                 t_val,
    output logic [3*N_APPROACH-1:0]       lamps,
    output logic                          walk_lamp,
    output logic [$clog2(N_APPROACH)-1:0] cur_app
);

    localparam int AW = $clog2(N_APPROACH);
    localparam logic [AW-1:0] LAST = AW'(N_APPROACH - 1);

    logic [1:0]    rst_sync;
    logic          rst_n_int;
    state_e        state, state_n;
    logic [AW-1:0] app_n, app_next;
    logic          entry;
    logic          expire;
    logic [TW-1:0] ivl [4];
    logic [TW-1:0] t_sat, load_val;
    logic          walk_latch;

    function automatic logic [3*N_APPROACH-1:0] lamp_decode(input state_e s,
                                                            input logic [AW-1:0] a);
        logic [3*N_APPROACH-1:0] l;
        l = '0;
        for (int i = 0; i < N_APPROACH; i++) begin
            if (s != WALK && AW'(i) == a)
                l[3*i + ((s == YELLOW) ? YEL : GRN)] = 1'b1;
            else
                l[3*i + RED] = 1'b1;
        end
        return l;
    endfunction

    // Assert asynchronously, release two clk edges after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    assign t_sat    = (t_val == '0) ? TW'(1) : t_val;
    assign app_next = (cur_app == LAST) ? '0 : cur_app + AW'(1);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_n = state;
        app_n   = cur_app;
        entry   = 1'b0;
        if (reprogram) begin
            state_n = GREEN_BASE;
            app_n   = '0;
            entry   = 1'b1;
        end else if (expire) begin
            entry = 1'b1;
            case (state)
                GREEN_BASE: state_n = sensor[cur_app] ? GREEN_EXT : YELLOW;
                GREEN_EXT:  state_n = YELLOW;
                YELLOW: begin
                    if (walk_latch) begin
                        state_n = WALK;
                    end else begin
                        state_n = GREEN_BASE;
                        app_n   = app_next;
                    end
                end
                default: begin
                    state_n = GREEN_BASE;
                    app_n   = app_next;
                end
            endcase
        end
    end

    // A reprogram restart uses the value being written in the same cycle.
    always_comb begin
        load_val = ivl[state_tp(state_n)];
        if (reprogram && tp_sel == state_tp(state_n))
            load_val = t_sat;
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state     <= GREEN_BASE;
            cur_app   <= '0;
            lamps     <= lamp_decode(GREEN_BASE, '0);
            walk_lamp <= 1'b0;
        end else begin
            state     <= state_n;
            cur_app   <= app_n;
            lamps     <= lamp_decode(state_n, app_n);
            walk_lamp <= (state_n == WALK);
        end
    end

    // NOTE: the four interval registers are a tiny register file with
    // defined power-up values, so they are reset like ordinary flops.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            ivl[TP_BASE] <= TW'(DEF_BASE);
            ivl[TP_EXT]  <= TW'(DEF_EXT);
            ivl[TP_YEL]  <= TW'(DEF_YEL);
            ivl[TP_WALK] <= TW'(DEF_WALK);
        end else if (reprogram) begin
            ivl[tp_sel] <= t_sat;
        end
    end

    // A press in any non-WALK cycle wins over the clear on WALK entry.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int)
            walk_latch <= 1'b0;
        else if (walk && state != WALK)
            walk_latch <= 1'b1;
        else if (entry && state_n == WALK)
            walk_latch <= 1'b0;
    end

    tick_timer #(
        .TICK_DIV (TICK_DIV),
        .TW       (TW),
        .RST_VAL  (DEF_BASE)
    ) u_timer (
        .clk      (clk),
        .reset_n  (rst_n_int),
        .load     (entry),
        .load_val (load_val),
        .expire   (expire)
    );

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed bench for traffic_ctrl_multi: a 2-approach and a 3-approach
// instance, both with TICK_DIV=4, checked against hand-computed durations.
module tb_traffic_ctrl_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, walk, reprogram;
    logic [1:0] sensor, tp_sel;
    logic [3:0] t_val;
    logic [5:0] lamps;
    logic       walk_lamp;
    logic [0:0] cur_app;

    logic       reset3_n, walk3, reprogram3;
    logic [2:0] sensor3;
    logic [1:0] tp_sel3;
    logic [3:0] t_val3;
    logic [8:0] lamps3;
    logic       walk_lamp3;
    logic [1:0] cur_app3;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [5:0] G0 = 6'b001100, Y0 = 6'b001010;
    localparam logic [5:0] G1 = 6'b100001, Y1 = 6'b010001, AR = 6'b001001;
    localparam logic [8:0] G0_3 = 9'b001001100, Y0_3 = 9'b001001010;
    localparam logic [8:0] G1_3 = 9'b001100001, Y1_3 = 9'b001010001;
    localparam logic [8:0] G2_3 = 9'b100001001, Y2_3 = 9'b010001001;

    traffic_ctrl_multi #(.N_APPROACH(2), .TICK_DIV(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .sensor(sensor), .walk(walk),
        .reprogram(reprogram), .tp_sel(tp_sel), .t_val(t_val),
        .lamps(lamps), .walk_lamp(walk_lamp), .cur_app(cur_app)
    );

    traffic_ctrl_multi #(.N_APPROACH(3), .TICK_DIV(4)) dut3 (
        .clk(clk), .reset_n(reset3_n), .sensor(sensor3), .walk(walk3),
        .reprogram(reprogram3), .tp_sel(tp_sel3), .t_val(t_val3),
        .lamps(lamps3), .walk_lamp(walk_lamp3), .cur_app(cur_app3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles until the 2-approach lamps change, bounded.
    task automatic run_len(output int c);
        logic [5:0] l0;
        l0 = lamps;
        c  = 0;
        do begin
            tick();
            c++;
        end while (lamps === l0 && c < 200);
    endtask

    task automatic wait_pat(input logic [5:0] p);
        int c;
        c = 0;
        while (lamps !== p && c < 300) begin
            tick();
            c++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; walk = 1'b0; reprogram = 1'b0;
        sensor = 2'b00; tp_sel = 2'b00; t_val = 4'd0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic do_reprog(input logic [1:0] sel, input logic [3:0] val);
        reprogram = 1'b1; tp_sel = sel; t_val = val;
        tick();
        reprogram = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (lamps !== G0 || walk_lamp !== 1'b0 || cur_app !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: lamps=%b walk_lamp=%b app=%0d, want lamps=%b walk_lamp=0 app=0",
                     lamps, walk_lamp, cur_app, G0);
        end
        repeat (4) tick();
        n_vec++;
        if (lamps !== G0 || walk_lamp !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: lamps=%b walk_lamp=%b, want lamps=%b walk_lamp=0",
                     lamps, walk_lamp, G0);
        end
    endtask

    task automatic test_idle();
        int c;
        int period;
        do_reset();
        wait_pat(Y0);
        n_vec++;
        if (lamps !== Y0 || cur_app !== 1'b0) begin
            n_err++;
            $display("FAIL idle_first_yellow: lamps=%b app=%0d, want lamps=%b app=0", lamps, cur_app, Y0);
        end
        run_len(c); period = c;
        n_vec++;
        if (c !== 8 || lamps !== G1 || cur_app !== 1'b1) begin
            n_err++;
            $display("FAIL idle_y0: len=%0d lamps=%b app=%0d, want len=8 lamps=%b app=1", c, lamps, cur_app, G1);
        end
        run_len(c); period += c;
        n_vec++;
        if (c !== 24 || lamps !== Y1) begin
            n_err++;
            $display("FAIL idle_g1: len=%0d lamps=%b, want len=24 lamps=%b", c, lamps, Y1);
        end
        run_len(c); period += c;
        n_vec++;
        if (c !== 8 || lamps !== G0 || cur_app !== 1'b0) begin
            n_err++;
            $display("FAIL idle_y1: len=%0d lamps=%b app=%0d, want len=8 lamps=%b app=0", c, lamps, cur_app, G0);
        end
        run_len(c); period += c;
        n_vec++;
        if (c !== 24 || lamps !== Y0) begin
            n_err++;
            $display("FAIL idle_g0: len=%0d lamps=%b, want len=24 lamps=%b", c, lamps, Y0);
        end
        n_vec++;
        if (period !== 64) begin
            n_err++;
            $display("FAIL idle_period: got %0d, want 64", period);
        end
    endtask

    task automatic test_sensor();
        int c;
        do_reset();
        sensor = 2'b01;
        wait_pat(G1);
        run_len(c);
        n_vec++;
        if (c !== 24 || lamps !== Y1) begin
            n_err++;
            $display("FAIL sensor_g1: len=%0d lamps=%b, want len=24 lamps=%b", c, lamps, Y1);
        end
        run_len(c);
        run_len(c);
        n_vec++;
        if (c !== 36 || lamps !== Y0) begin
            n_err++;
            $display("FAIL sensor_g0_ext: len=%0d lamps=%b, want len=36 lamps=%b", c, lamps, Y0);
        end
        run_len(c);
        n_vec++;
        if (c !== 8 || lamps !== G1) begin
            n_err++;
            $display("FAIL sensor_y0: len=%0d lamps=%b, want len=8 lamps=%b", c, lamps, G1);
        end
        sensor = 2'b00;
    endtask

    task automatic test_walk();
        int c;
        do_reset();
        repeat (5) tick();
        walk = 1'b1; tick(); walk = 1'b0;
        wait_pat(Y0);
        run_len(c);
        n_vec++;
        if (c !== 8 || lamps !== AR || walk_lamp !== 1'b1 || cur_app !== 1'b0) begin
            n_err++;
            $display("FAIL walk_entry: len=%0d lamps=%b walk_lamp=%b app=%0d, want len=8 lamps=%b walk_lamp=1 app=0",
                     c, lamps, walk_lamp, cur_app, AR);
        end
        walk = 1'b1; tick(); walk = 1'b0;
        run_len(c);
        n_vec++;
        if (c + 1 !== 12 || lamps !== G1 || walk_lamp !== 1'b0 || cur_app !== 1'b1) begin
            n_err++;
            $display("FAIL walk_phase: len=%0d lamps=%b walk_lamp=%b app=%0d, want len=12 lamps=%b walk_lamp=0 app=1",
                     c + 1, lamps, walk_lamp, cur_app, G1);
        end
        run_len(c);
        run_len(c);
        n_vec++;
        if (c !== 8 || lamps !== G0 || walk_lamp !== 1'b0) begin
            n_err++;
            $display("FAIL walk_no_repeat_y1: len=%0d lamps=%b walk_lamp=%b, want len=8 lamps=%b walk_lamp=0",
                     c, lamps, walk_lamp, G0);
        end
        run_len(c);
        run_len(c);
        n_vec++;
        if (c !== 8 || lamps !== G1 || walk_lamp !== 1'b0) begin
            n_err++;
            $display("FAIL walk_no_repeat_y0: len=%0d lamps=%b walk_lamp=%b, want len=8 lamps=%b walk_lamp=0",
                     c, lamps, walk_lamp, G1);
        end
    endtask

    task automatic test_reprogram();
        int c;
        do_reset();
        repeat (5) tick();
        do_reprog(2'b00, 4'd2);
        n_vec++;
        if (lamps !== G0 || cur_app !== 1'b0) begin
            n_err++;
            $display("FAIL reprog_restart: lamps=%b app=%0d, want lamps=%b app=0", lamps, cur_app, G0);
        end
        run_len(c);
        n_vec++;
        if (c !== 8 || lamps !== Y0) begin
            n_err++;
            $display("FAIL reprog_base2_g0: len=%0d lamps=%b, want len=8 lamps=%b", c, lamps, Y0);
        end
        run_len(c);
        run_len(c);
        n_vec++;
        if (c !== 8 || lamps !== Y1) begin
            n_err++;
            $display("FAIL reprog_base2_g1: len=%0d lamps=%b, want len=8 lamps=%b", c, lamps, Y1);
        end
        walk = 1'b1; tick(); walk = 1'b0;
        tick();
        do_reprog(2'b00, 4'd0);
        n_vec++;
        if (lamps !== G0 || cur_app !== 1'b0) begin
            n_err++;
            $display("FAIL reprog_mid_yellow: lamps=%b app=%0d, want lamps=%b app=0", lamps, cur_app, G0);
        end
        run_len(c);
        n_vec++;
        if (c !== 4 || lamps !== Y0) begin
            n_err++;
            $display("FAIL reprog_zero_as_one: len=%0d lamps=%b, want len=4 lamps=%b", c, lamps, Y0);
        end
        run_len(c);
        n_vec++;
        if (c !== 8 || lamps !== AR || walk_lamp !== 1'b1) begin
            n_err++;
            $display("FAIL reprog_keeps_walk: len=%0d lamps=%b walk_lamp=%b, want len=8 lamps=%b walk_lamp=1",
                     c, lamps, walk_lamp, AR);
        end
        run_len(c);
        run_len(c);
        n_vec++;
        if (c !== 4 || lamps !== Y1) begin
            n_err++;
            $display("FAIL reprog_base1_g1: len=%0d lamps=%b, want len=4 lamps=%b", c, lamps, Y1);
        end
    endtask

    task automatic test_async_reset();
        int c;
        do_reset();
        repeat (5) tick();
        do_reprog(2'b00, 4'd2);
        wait_pat(G1);
        walk = 1'b1; tick(); walk = 1'b0;
        wait_pat(Y1);
        repeat (3) tick();
        #3;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (lamps !== G0 || walk_lamp !== 1'b0 || cur_app !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_now: lamps=%b walk_lamp=%b app=%0d, want lamps=%b walk_lamp=0 app=0",
                     lamps, walk_lamp, cur_app, G0);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        wait_pat(Y0);
        run_len(c);
        n_vec++;
        if (c !== 8 || lamps !== G1 || walk_lamp !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_latch: len=%0d lamps=%b walk_lamp=%b, want len=8 lamps=%b walk_lamp=0",
                     c, lamps, walk_lamp, G1);
        end
        run_len(c);
        n_vec++;
        if (c !== 24 || lamps !== Y1) begin
            n_err++;
            $display("FAIL async_reset_defaults: len=%0d lamps=%b, want len=24 lamps=%b", c, lamps, Y1);
        end
    endtask

    task automatic test_three();
        int          exp_len [6];
        logic [8:0]  exp_pat [6];
        logic [1:0]  exp_app [6];
        logic [8:0]  l0;
        int          c;
        int          bad;
        exp_len = '{8, 24, 8, 24, 8, 24};
        exp_pat = '{G1_3, Y1_3, G2_3, Y2_3, G0_3, Y0_3};
        exp_app = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
        bad = 0;
        walk3 = 1'b0; reprogram3 = 1'b0; sensor3 = 3'b000; tp_sel3 = 2'b00; t_val3 = 4'd0;
        reset3_n = 1'b0;
        repeat (2) tick();
        n_vec++;
        if (lamps3 !== G0_3 || cur_app3 !== 2'd0 || walk_lamp3 !== 1'b0) begin
            n_err++;
            $display("FAIL n3_reset: lamps=%b app=%0d walk_lamp=%b, want lamps=%b app=0 walk_lamp=0",
                     lamps3, cur_app3, walk_lamp3, G0_3);
        end
        reset3_n = 1'b1;
        c = 0;
        while (lamps3 === G0_3 && c < 200) begin
            tick();
            c++;
        end
        n_vec++;
        if (lamps3 !== Y0_3 || cur_app3 !== 2'd0) begin
            n_err++;
            $display("FAIL n3_first_yellow: lamps=%b app=%0d, want lamps=%b app=0", lamps3, cur_app3, Y0_3);
        end
        for (int k = 0; k < 6; k++) begin
            l0 = lamps3;
            c  = 0;
            do begin
                tick();
                c++;
                for (int a = 0; a < 3; a++)
                    if ($countones(lamps3[3*a +: 3]) != 1) bad++;
            end while (lamps3 === l0 && c < 200);
            n_vec++;
            if (c !== exp_len[k] || lamps3 !== exp_pat[k] || cur_app3 !== exp_app[k]) begin
                n_err++;
                $display("FAIL n3_phase%0d: len=%0d lamps=%b app=%0d, want len=%0d lamps=%b app=%0d",
                         k, c, lamps3, cur_app3, exp_len[k], exp_pat[k], exp_app[k]);
            end
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL n3_one_lamp: bad approach-cycles=%0d, want 0", bad);
        end
    endtask

    initial begin
        reset3_n = 1'b0; walk3 = 1'b0; reprogram3 = 1'b0;
        sensor3 = 3'b000; tp_sel3 = 2'b00; t_val3 = 4'd0;
        test_reset();
        test_idle();
        test_sensor();
        test_walk();
        test_reprogram();
        test_async_reset();
        test_three();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_multi.md
# traffic_ctrl_multi

Parametrised N-approach traffic light controller, successor of the fixed two-way `controller`. Cycles green/yellow across `N_APPROACH` approaches in round-robin order, extends green once on sensor demand, inserts an all-red pedestrian walk phase on request, and supports runtime reprogramming of four interval registers. Intervals are counted in ticks from an internal prescaler. Lamp outputs drive the board LED/driver layer directly.

## Interface
- `N_APPROACH`, 2: number of approaches, ≥2.
- `TICK_DIV`, 100_000_000: clk cycles per tick (one "second"). Benches use 4.
- `TW`, 4: width of `t_val` and interval registers.
- `DEF_BASE`, 6: reset value of the base green interval, in ticks.
- `DEF_EXT`, 3: reset value of the green extension interval, in ticks.
- `DEF_YEL`, 2: reset value of the yellow interval, in ticks.
- `DEF_WALK`, 3: reset value of the walk interval, in ticks.

- `clk` in 1: single clock, all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `sensor` in N_APPROACH: per-approach vehicle demand, level.
- `walk` in 1: pedestrian request, level; any high cycle latches a request.
- `reprogram` in 1: load strobe for the interval registers.
- `tp_sel` in 2: register select. 00 base, 01 ext, 10 yellow, 11 walk.
- `t_val` in TW: value to load, in ticks.
- `lamps` out 3*N_APPROACH: per approach i, bit 3i = red, 3i+1 = yellow, 3i+2 = green.
- `walk_lamp` out 1: pedestrian walk indicator.
- `cur_app` out $clog2(N_APPROACH): index of the approach being served.

## Operation
- States: GREEN_BASE, GREEN_EXT, YELLOW, WALK.
- Reset values:
  - State GREEN_BASE, `cur_app` 0.
  - Approach 0 green, all other approaches red, `walk_lamp` 0.
  - Walk latch cleared; interval registers at their DEF_* values; prescaler at 0.
- GREEN_BASE → at expiry:
  - GREEN_EXT if `sensor[cur_app]` is high in the expiry cycle.
  - Otherwise YELLOW.
- GREEN_EXT → YELLOW at expiry. Extension is granted at most once per green.
- YELLOW → at expiry:
  - WALK if the walk latch is set.
  - Otherwise GREEN_BASE with `cur_app` advanced by one, wrapping N_APPROACH-1 → 0.
- WALK:
  - All approaches red, `walk_lamp` 1.
  - Walk latch is cleared on entry; `walk` is ignored while in WALK.
  - At expiry → GREEN_BASE of the next approach.
- Lamp rules:
  - Exactly one lamp is lit per approach at all times.
  - Non-served approaches show red.
- Reprogram: in a cycle with `reprogram`=1:
  - reg[`tp_sel`] ← `t_val`; a `t_val` of 0 is stored as 1.
  - FSM restarts at GREEN_BASE, `cur_app` 0, using the new values.
  - Walk latch is kept.
  - Holding `reprogram` high keeps the FSM in restart.
- A `walk` press in the same cycle as YELLOW expiry is latched, but does not take effect until the next YELLOW expiry.

## Timing
- Outputs are registered and change one cycle after the deciding edge.
- On every state entry, the prescaler clears and the tick counter loads the interval register for the new state.
- Each state lasts exactly interval × TICK_DIV cycles.
- Expiry is the cycle in which the tick counter equals 1 and the prescaler equals TICK_DIV-1.
- Interval register writes take effect at the next state entry. A reprogram restart is itself a state entry.
- Assertion of `reset_n` forces all outputs to their reset values immediately, even mid-state. Release is synchronised through a 2-flop deassertion synchroniser.

## Structure
- `traffic_pkg` holds:
  - the state enum;
  - the `tp_sel` encodings TP_BASE, TP_EXT, TP_YEL, TP_WALK;
  - lamp bit offsets RED=0, YEL=1, GRN=2.
- Sub-module `tick_timer`: prescaler plus TW-bit down-counter.
  - Ports: `clk`, `reset_n`, `load`, `load_val`.
  - Output `expire` is a single-cycle pulse.
- Top module contains the FSM, interval registers, walk latch and lamp decode.

## Test plan
All scenarios use TICK_DIV=4, N_APPROACH=2 and default intervals unless noted.
- Idle run after reset release, no inputs:
  - Green/yellow durations: approach 0 green 24 cycles, yellow 8; approach 1 green 24, yellow 8.
  - Repeats with a 64-cycle period.
  - `cur_app` sequence 0,1,0.
- `sensor[0]` held high: approach 0 green lasts 36 cycles, then yellow 8. `sensor[1]`=0 leaves approach 1 green at 24.
- One-cycle `walk` pulse during approach 0 green:
  - After approach 0 yellow: all red with `walk_lamp`=1 for 12 cycles.
  - Then approach 1 green.
  - No second walk phase follows.
- `reprogram`=1 for one cycle with `tp_sel`=00, `t_val`=2 → next cycle approach 0 green, lasting 8 cycles. Repeat with `t_val`=0 → green lasts 4 cycles.
- `reset_n` pulled low mid-yellow of approach 1:
  - Lamps switch to approach 0 green without waiting for a clk edge.
  - After release: walk latch clear, intervals back to defaults.
- N_APPROACH=3, idle: `cur_app` sequence 0,1,2,0; each approach green 24 cycles; exactly one lamp lit per approach in every cycle.
